// File: rtl/sound_tone_gen_if.sv
// Sound request/response bundle between the game FSM (master) and the tone generator (slave).
// Requests are level-sampled every clk; outputs are registered in the generator.
interface sound_tone_gen_if #(
    parameter int FREQ_W   = 10,
    parameter int SAMPLE_W = 16
);
    logic                       enable_sound;
    logic [FREQ_W-1:0]          sound_freq;
    logic                       tone_out;
    logic signed [SAMPLE_W-1:0] audio_sample;
    logic                       sample_valid;
    logic                       busy;

    modport master (
        output enable_sound,
        output sound_freq,
        input  tone_out,
        input  audio_sample,
        input  sample_valid,
        input  busy
    );

    modport slave (
        input  enable_sound,
        input  sound_freq,
        output tone_out,
        output audio_sample,
        output sample_valid,
        output busy
    );
endinterface

// File: rtl/sound_tone_gen.sv
// Square-wave tone generator with click-free release: half-period = sound_freq ticks of PRESCALE clks.
// Request seen on one edge is audible after that edge; no backpressure, sample_valid is a free-running strobe.
module sound_tone_gen #(
    parameter int PRESCALE  = 50,
    parameter int FREQ_W    = 10,
    parameter int SAMPLE_W  = 16,
    parameter int AMPLITUDE = 16'h3FFF
) (
    input  logic             clk,
    input  logic             resetN,
    sound_tone_gen_if.slave  snd
);
    localparam int PW = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PRESCALE_LAST = PW'(PRESCALE - 1);
    localparam logic signed [SAMPLE_W-1:0] AMP_POS = SAMPLE_W'(AMPLITUDE);
    localparam logic signed [SAMPLE_W-1:0] AMP_NEG = -AMP_POS;

    typedef enum logic [1:0] {IDLE, PLAY, RELEASE} state_t;

    state_t            state;
    logic [PW-1:0]     prescale_cnt;
    logic [FREQ_W-1:0] phase_cnt;
    logic [FREQ_W-1:0] period_reg;

    logic tick;
    logic play_req;
    logic boundary;

    assign tick     = (prescale_cnt == PRESCALE_LAST);
    assign play_req = snd.enable_sound && (snd.sound_freq != '0);
    assign boundary = tick && (phase_cnt == period_reg - 1'b1);

    always_ff @(posedge clk or posedge resetN) begin
        if (resetN) begin
            state            <= IDLE;
            prescale_cnt     <= '0;
            phase_cnt        <= '0;
            period_reg       <= '0;
            snd.tone_out     <= 1'b0;
            snd.audio_sample <= '0;
            snd.sample_valid <= 1'b0;
            snd.busy         <= 1'b0;
        end else begin
            snd.sample_valid <= tick;
            prescale_cnt     <= tick ? '0 : prescale_cnt + 1'b1;

            case (state)
                IDLE: begin
                    if (play_req) begin
                        // Restart the prescaler so every note starts with a full first tick.
                        prescale_cnt     <= '0;
                        period_reg       <= snd.sound_freq;
                        phase_cnt        <= '0;
                        state            <= PLAY;
                        snd.tone_out     <= 1'b1;
                        snd.audio_sample <= AMP_POS;
                        snd.busy         <= 1'b1;
                    end
                end

                PLAY, RELEASE: begin
                    if (tick) begin
                        phase_cnt <= boundary ? '0 : phase_cnt + 1'b1;
                    end

                    if (boundary && !play_req && (snd.tone_out || state == RELEASE)) begin
                        // Falling edge, or end of the low half while releasing: stop silently.
                        state            <= IDLE;
                        snd.tone_out     <= 1'b0;
                        snd.audio_sample <= '0;
                        snd.busy         <= 1'b0;
                    end else if (boundary) begin
                        state            <= play_req ? PLAY : RELEASE;
                        snd.tone_out     <= ~snd.tone_out;
                        snd.audio_sample <= snd.tone_out ? AMP_NEG : AMP_POS;
                        if ((state == PLAY || play_req) && snd.sound_freq != '0) begin
                            period_reg <= snd.sound_freq;
                        end
                    end else begin
                        state <= play_req ? PLAY : RELEASE;
                    end
                end

                default: begin
                    state            <= IDLE;
                    snd.tone_out     <= 1'b0;
                    snd.audio_sample <= '0;
                    snd.busy         <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_sound_tone_gen.sv
// Directed bench for sound_tone_gen at PRESCALE=4; expected timings are hand-derived edge counts.
module tb_sound_tone_gen;
    localparam logic [15:0] POS = 16'h3FFF;
    localparam logic [15:0] NEG = 16'hC001;

    logic clk;
    logic resetN;
    int   checks;
    int   errors;

    sound_tone_gen_if #(.FREQ_W(10), .SAMPLE_W(16)) snd_if ();

    sound_tone_gen #(
        .PRESCALE  (4),
        .FREQ_W    (10),
        .SAMPLE_W  (16),
        .AMPLITUDE (16'h3FFF)
    ) dut (
        .clk    (clk),
        .resetN (resetN),
        .snd    (snd_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic adv(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic expect_out(input string tag, input logic tone, input logic [15:0] smp, input logic bsy);
        check({tag, ".tone"},   {31'd0, snd_if.tone_out},     {31'd0, tone});
        check({tag, ".sample"}, {16'd0, snd_if.audio_sample}, {16'd0, smp});
        check({tag, ".busy"},   {31'd0, snd_if.busy},         {31'd0, bsy});
    endtask

    initial begin
        checks = 0;
        errors = 0;
        resetN = 1'b1;
        snd_if.enable_sound = 1'b1;
        snd_if.sound_freq   = 10'd5;

        // Reset held with a pending request: everything quiet.
        adv(3);
        expect_out("rst", 1'b0, 16'h0, 1'b0);
        check("rst.valid", {31'd0, snd_if.sample_valid}, 32'd0);
        resetN = 1'b0;
        check("rel.busy0", {31'd0, snd_if.busy}, 32'd0);
        adv(2);
        check("rel.busy1", {31'd0, snd_if.busy}, 32'd1);
        check("rel.tone1", {31'd0, snd_if.tone_out}, 32'd1);

        resetN = 1'b1;
        snd_if.enable_sound = 1'b0;
        snd_if.sound_freq   = 10'd3;
        adv(1);
        resetN = 1'b0;
        adv(2);

        // Basic tone, half-period 3 ticks = 12 clks.
        snd_if.enable_sound = 1'b1;
        adv(1);
        expect_out("t2.start", 1'b1, POS, 1'b1);
        adv(4);
        check("t2.valid_hi", {31'd0, snd_if.sample_valid}, 32'd1);
        adv(1);
        check("t2.valid_lo", {31'd0, snd_if.sample_valid}, 32'd0);
        adv(6);
        check("t2.high_end", {31'd0, snd_if.tone_out}, 32'd1);
        adv(1);
        expect_out("t2.fall", 1'b0, NEG, 1'b1);
        check("t2.fall_valid", {31'd0, snd_if.sample_valid}, 32'd1);
        adv(11);
        check("t2.low_end", {31'd0, snd_if.tone_out}, 32'd0);
        adv(1);
        expect_out("t2.rise", 1'b1, POS, 1'b1);

        // Frequency change mid-high: current half keeps 12 clks, next half is 24.
        adv(2);
        snd_if.sound_freq = 10'd6;
        adv(9);
        check("t3.high_end", {31'd0, snd_if.tone_out}, 32'd1);
        adv(1);
        check("t3.fall", {31'd0, snd_if.tone_out}, 32'd0);
        adv(23);
        check("t3.low_end", {31'd0, snd_if.tone_out}, 32'd0);
        adv(1);
        check("t3.rise", {31'd0, snd_if.tone_out}, 32'd1);

        // Release two ticks into a 24-clk high half.
        adv(8);
        snd_if.enable_sound = 1'b0;
        adv(15);
        expect_out("t4.tail", 1'b1, POS, 1'b1);
        adv(1);
        expect_out("t4.stop", 1'b0, 16'h0, 1'b0);
        adv(6);
        expect_out("t4.idle", 1'b0, 16'h0, 1'b0);

        // Re-trigger during a released low half: rise stays on schedule.
        snd_if.sound_freq   = 10'd3;
        snd_if.enable_sound = 1'b1;
        adv(1);
        check("t5.start", {31'd0, snd_if.tone_out}, 32'd1);
        adv(12);
        check("t5.fall", {31'd0, snd_if.tone_out}, 32'd0);
        adv(2);
        snd_if.enable_sound = 1'b0;
        adv(2);
        check("t5.rel_busy", {31'd0, snd_if.busy}, 32'd1);
        adv(2);
        snd_if.enable_sound = 1'b1;
        adv(5);
        expect_out("t5.pre_rise", 1'b0, NEG, 1'b1);
        adv(1);
        expect_out("t5.rise", 1'b1, POS, 1'b1);

        // Release in a low half: the rise is suppressed, idle at the boundary.
        adv(12);
        check("t5b.fall", {31'd0, snd_if.tone_out}, 32'd0);
        adv(2);
        snd_if.enable_sound = 1'b0;
        adv(9);
        expect_out("t5b.tail", 1'b0, NEG, 1'b1);
        adv(1);
        expect_out("t5b.stop", 1'b0, 16'h0, 1'b0);

        // Zero frequency never leaves IDLE; reset mid-note is immediate.
        snd_if.sound_freq   = 10'd0;
        snd_if.enable_sound = 1'b1;
        adv(10);
        expect_out("t6.zero", 1'b0, 16'h0, 1'b0);
        snd_if.sound_freq = 10'd5;
        adv(1);
        expect_out("t6.play", 1'b1, POS, 1'b1);
        adv(5);
        #2;
        resetN = 1'b1;
        #1;
        expect_out("t6.async_rst", 1'b0, 16'h0, 1'b0);
        adv(2);
        resetN = 1'b0;
        adv(1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
